// File: rtl/sync_code_pkg.sv
// Shared constants and state encoding for the sync-code inserter.
// DATA_W     : width of pixel / stream words.
// SYNC_WORD  : leading word of every sync sequence; never allowed in payload.
// ZERO_WORD  : filler word for idle, sync tail and blanking.
// CLAMP_WORD : substitute for a payload pixel equal to SYNC_WORD.
// state_t    : line generator states.
package sync_code_pkg;

    localparam int DATA_W = 12;

    localparam logic [DATA_W-1:0] SYNC_WORD  = 12'hFFF;
    localparam logic [DATA_W-1:0] ZERO_WORD  = 12'h000;
    localparam logic [DATA_W-1:0] CLAMP_WORD = 12'hFFE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC0  = 3'd1,
        SYNC1  = 3'd2,
        SYNC2  = 3'd3,
        ACTIVE = 3'd4,
        BLANK  = 3'd5
    } state_t;

endpackage

// File: rtl/sync_code_inserter.sv
// Sync-code inserter: wraps a pixel stream into sensor-style lines of
//   SYNC_WORD, ZERO_WORD, ZERO_WORD, LINE_PIXELS payload words,
//   BLANK_WORDS zero words, repeating while enable is high.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous, active-high reset
//   enable      : level request for continuous line generation
//   pix_data    : source pixel word
//   pix_valid   : pix_data is valid
//   pix_ready   : a pixel slot is consumed this cycle (ACTIVE only)
//   data_out    : registered output stream word
//   line_toggle : inverts once per emitted sync sequence
//   busy        : generator is not IDLE
//   underrun    : sticky, an ACTIVE slot had no valid pixel (cleared by rst)
module sync_code_inserter
    import sync_code_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int BLANK_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              line_toggle,
    output logic              busy,
    output logic              underrun
);

    localparam int LINE_CNT_W  = $clog2(LINE_PIXELS + 1);
    localparam int BLANK_CNT_W = $clog2(BLANK_WORDS + 1);
    localparam int CNT_W       = (LINE_CNT_W > BLANK_CNT_W) ? LINE_CNT_W : BLANK_CNT_W;

    // The shared down-counter is loaded with (length - 1) and the phase ends
    // on the cycle it reads zero, so a length of 1 gives exactly one cycle.
    localparam logic [CNT_W-1:0] LINE_LAST  = CNT_W'(LINE_PIXELS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_WORDS - 1);

    // Keep the sync word out of the payload.
    function automatic logic [DATA_W-1:0] clamp_pixel(input logic [DATA_W-1:0] px);
        return (px == SYNC_WORD) ? CLAMP_WORD : px;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            data_out    <= ZERO_WORD;
            line_toggle <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    data_out <= ZERO_WORD;
                    if (enable) state <= SYNC0;
                end
                SYNC0: begin
                    data_out <= SYNC_WORD;
                    state    <= SYNC1;
                end
                SYNC1: begin
                    data_out <= ZERO_WORD;
                    state    <= SYNC2;
                end
                SYNC2: begin
                    // Toggle lands on the same edge as the third sync word.
                    data_out    <= ZERO_WORD;
                    line_toggle <= ~line_toggle;
                    cnt         <= LINE_LAST;
                    state       <= ACTIVE;
                end
                ACTIVE: begin
                    // A missing pixel still uses up its slot in the line.
                    if (pix_valid) begin
                        data_out <= clamp_pixel(pix_data);
                    end else begin
                        data_out <= ZERO_WORD;
                        underrun <= 1'b1;
                    end
                    if (cnt == '0) begin
                        cnt   <= BLANK_LAST;
                        state <= BLANK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BLANK: begin
                    data_out <= ZERO_WORD;
                    if (cnt == '0) begin
                        state <= enable ? SYNC0 : IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    data_out <= ZERO_WORD;
                    cnt      <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign pix_ready = (state == ACTIVE);
    assign busy      = (state != IDLE);

endmodule
